// File: rtl/spu_env_pkg.sv
// Shared encodings and constants for the SPU ADSR envelope stepper.
// The optional ENV_ATTACK_EXP_EN build uses ATTACK_KNEE for the pseudo-exponential attack.
package spu_env_pkg;

  localparam logic [14:0] LEVEL_MAX   = 15'h7FFF;
  localparam logic [14:0] SL_UNIT     = 15'h0800;
  localparam logic [14:0] ATTACK_KNEE = 15'h6000;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } env_phase_t;

  typedef enum logic [1:0] {
    SEQ_WAIT   = 2'd0,
    SEQ_LOOKUP = 2'd1,
    SEQ_APPLY  = 2'd2
  } seq_state_t;

  // sl=15 would land exactly on 0x8000, one past the ceiling
  function automatic logic [14:0] sustain_target(input logic [3:0] sl);
    logic [15:0] t;
    t = {1'b0, sl, 11'b0} + {1'b0, SL_UNIT};
    return (t > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : t[14:0];
  endfunction

endpackage

// File: rtl/spu_adsr_envelope_if.sv
// Rate-sub ROM port: the envelope addresses the ROM, the ROM returns a signed step one cycle later.
interface spu_adsr_envelope_if;
  logic [6:0]  rt_adrs;
  logic        rt_read;
  logic [14:0] rt_dout;

  modport master (output rt_adrs, output rt_read, input rt_dout);
  modport slave  (input rt_adrs, input rt_read, output rt_dout);
endinterface

// File: rtl/spu_env_expstep.sv
// Exponential decrement: level - max((m*level)>>15, m!=0), floored at zero.
module spu_env_expstep (
  input  logic [15:0] m,
  input  logic [14:0] level,
  output logic [14:0] level_next
);

  logic [30:0] prod;
  logic [15:0] d;

  assign prod = 31'(m) * 31'(level);

  // Small levels would otherwise stall forever; force at least one LSB of progress
  always_comb begin
    d = prod[30:15];
    if (m != 16'd0 && d == 16'd0) d = 16'd1;
    level_next = ({1'b0, level} > d) ? 15'({1'b0, level} - d) : 15'd0;
  end

endmodule

// File: rtl/spu_adsr_envelope.sv
// Single-voice ADSR envelope stepper driving the rate-sub ROM.
// Build option: define ENV_ATTACK_EXP_EN for the quartered attack step above the knee.
module spu_adsr_envelope
  import spu_env_pkg::*;
(
  input  logic                 m_clock,
  input  logic                 p_reset,
  input  logic                 tick,
  input  logic                 key_on,
  input  logic                 key_off,
  input  logic [6:0]           ar,
  input  logic [3:0]           dr,
  input  logic [3:0]           sl,
  input  logic [6:0]           sr,
  input  logic                 sr_dec,
  input  logic [4:0]           rr,
  input  logic                 rr_exp,
  spu_adsr_envelope_if.master  rt,
  output logic [14:0]          env_level,
  output logic [2:0]           env_phase,
  output logic                 step_done,
  output logic                 tick_overrun
);

  seq_state_t  state_q, state_d;
  env_phase_t  phase_q, phase_d, tick_phase;
  logic [14:0] level_q, level_d;
  logic [6:0]  adrs_q, adrs_d, lookup_adrs;
  logic        read_q, read_d, done_q, done_d;
  logic        pend_on_q, pend_on_d, pend_off_q, pend_off_d;
  logic        ovr_q, ovr_d;
  logic        on_req, off_req;

  logic signed [15:0] dout_sx;
  logic [15:0] m, inc;
  logic [16:0] sum;
  logic [14:0] lin_up, lin_dn, exp_dn, rel_lvl, sus_target;

  assign on_req  = pend_on_q | key_on;
  assign off_req = pend_off_q | key_off;

  always_comb begin
    if (on_req)
      tick_phase = PH_ATTACK;
    else if (off_req && phase_q != PH_IDLE)
      tick_phase = PH_RELEASE;
    else
      tick_phase = phase_q;
  end

  always_comb begin
    case (tick_phase)
      PH_ATTACK:  lookup_adrs = ar;
      PH_DECAY:   lookup_adrs = {1'b0, dr, 2'b00};
      PH_SUSTAIN: lookup_adrs = sr;
      PH_RELEASE: lookup_adrs = {rr, 2'b00};
      default:    lookup_adrs = 7'd0;
    endcase
  end

  // ROM steps are non-positive, so the negation gives the step magnitude
  assign dout_sx = {rt.rt_dout[14], rt.rt_dout};
  assign m       = 16'(-dout_sx);

`ifdef ENV_ATTACK_EXP_EN
  assign inc = (phase_q == PH_ATTACK && level_q > ATTACK_KNEE) ? (m >> 2) : m;
`else
  assign inc = m;
`endif

  assign sum        = {2'b00, level_q} + {1'b0, inc};
  assign lin_up     = (sum > {2'b00, LEVEL_MAX}) ? LEVEL_MAX : sum[14:0];
  assign lin_dn     = ({1'b0, level_q} >= m) ? 15'({1'b0, level_q} - m) : 15'd0;
  assign rel_lvl    = rr_exp ? exp_dn : lin_dn;
  assign sus_target = sustain_target(sl);

  spu_env_expstep u_expstep (
    .m          (m),
    .level      (level_q),
    .level_next (exp_dn)
  );

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q    <= SEQ_WAIT;
      phase_q    <= PH_IDLE;
      level_q    <= 15'd0;
      adrs_q     <= 7'd0;
      read_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_on_q  <= 1'b0;
      pend_off_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      level_q    <= level_d;
      adrs_q     <= adrs_d;
      read_q     <= read_d;
      done_q     <= done_d;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      ovr_q      <= ovr_d;
    end
  end

  // Key events are resolved at tick time so the lookup already uses the new phase
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    level_d    = level_q;
    adrs_d     = adrs_q;
    read_d     = 1'b0;
    done_d     = 1'b0;
    pend_on_d  = pend_on_q | key_on;
    pend_off_d = pend_off_q | key_off;
    ovr_d      = ovr_q;
    if (tick && state_q != SEQ_WAIT) ovr_d = 1'b1;
    if (key_on) ovr_d = 1'b0;

    case (state_q)
      SEQ_WAIT: begin
        if (tick) begin
          pend_on_d  = 1'b0;
          pend_off_d = 1'b0;
          if (tick_phase != PH_IDLE) begin
            phase_d = tick_phase;
            if (on_req) level_d = 15'd0;
            adrs_d  = lookup_adrs;
            read_d  = 1'b1;
            state_d = SEQ_LOOKUP;
          end
        end
      end
      SEQ_LOOKUP: state_d = SEQ_APPLY;
      SEQ_APPLY: begin
        done_d  = 1'b1;
        state_d = SEQ_WAIT;
        case (phase_q)
          PH_ATTACK: begin
            level_d = lin_up;
            if (lin_up == LEVEL_MAX) phase_d = PH_DECAY;
          end
          PH_DECAY: begin
            if (exp_dn <= sus_target) begin
              level_d = sus_target;
              phase_d = PH_SUSTAIN;
            end else begin
              level_d = exp_dn;
            end
          end
          PH_SUSTAIN: level_d = sr_dec ? exp_dn : lin_up;
          PH_RELEASE: begin
            level_d = rel_lvl;
            if (rel_lvl == 15'd0) phase_d = PH_IDLE;
          end
          default: ;
        endcase
      end
      default: state_d = SEQ_WAIT;
    endcase
  end

  assign rt.rt_adrs   = adrs_q;
  assign rt.rt_read   = read_q;
  assign env_level    = level_q;
  assign env_phase    = phase_q;
  assign step_done    = done_q;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_spu_adsr_envelope.sv
// Self-checking bench for spu_adsr_envelope with a rule-level reference model and a modelled rate ROM.
module tb_spu_adsr_envelope;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        tick, key_on, key_off;
  logic [6:0]  ar, sr;
  logic [3:0]  dr, sl;
  logic        sr_dec, rr_exp;
  logic [4:0]  rr;
  logic [14:0] env_level;
  logic [2:0]  env_phase;
  logic        step_done, tick_overrun;

  int checks = 0;
  int errors = 0;

  int ref_level, ref_phase;
  bit ref_pon, ref_poff;

  spu_adsr_envelope_if rt_bus ();

  spu_adsr_envelope dut (
    .m_clock      (m_clock),
    .p_reset      (p_reset),
    .tick         (tick),
    .key_on       (key_on),
    .key_off      (key_off),
    .ar           (ar),
    .dr           (dr),
    .sl           (sl),
    .sr           (sr),
    .sr_dec       (sr_dec),
    .rr           (rr),
    .rr_exp       (rr_exp),
    .rt           (rt_bus),
    .env_level    (env_level),
    .env_phase    (env_phase),
    .step_done    (step_done),
    .tick_overrun (tick_overrun)
  );

  always #5 m_clock = ~m_clock;

  // Rate ROM: step halves every four addresses from -16384, zero from 0x39 up
  function automatic int rom_val(input int a);
    return (a >= 57) ? 0 : -(16384 >> (a / 4));
  endfunction

  always @(posedge m_clock)
    if (rt_bus.rt_read) rt_bus.rt_dout <= 15'(rom_val(int'(rt_bus.rt_adrs)));

  function automatic int ref_exp(input int level, input int m);
    int d;
    d = (m * level) / 32768;
    if (m != 0 && d == 0) d = 1;
    return (level > d) ? level - d : 0;
  endfunction

  // Reference: resolve keys, look up the step for the phase, apply the phase rule
  task automatic model_tick(output bit done);
    int addr, m, inc, t, nl;
    if (ref_pon) begin
      ref_level = 0;
      ref_phase = 1;
    end else if (ref_poff && ref_phase != 0) begin
      ref_phase = 4;
    end
    ref_pon  = 0;
    ref_poff = 0;
    done = (ref_phase != 0);
    if (!done) return;
    case (ref_phase)
      1:       addr = int'(ar);
      2:       addr = int'(dr) * 4;
      3:       addr = int'(sr);
      default: addr = int'(rr) * 4;
    endcase
    m = -rom_val(addr);
    case (ref_phase)
      1: begin
        inc = m;
`ifdef ENV_ATTACK_EXP_EN
        if (ref_level > 'h6000) inc = m / 4;
`endif
        ref_level = (ref_level + inc > 32767) ? 32767 : ref_level + inc;
        if (ref_level == 32767) ref_phase = 2;
      end
      2: begin
        t  = ((int'(sl) + 1) * 2048 > 32767) ? 32767 : (int'(sl) + 1) * 2048;
        nl = ref_exp(ref_level, m);
        if (nl <= t) begin
          ref_level = t;
          ref_phase = 3;
        end else begin
          ref_level = nl;
        end
      end
      3: begin
        if (sr_dec) ref_level = ref_exp(ref_level, m);
        else ref_level = (ref_level + m > 32767) ? 32767 : ref_level + m;
      end
      default: begin
        if (rr_exp) ref_level = ref_exp(ref_level, m);
        else ref_level = (ref_level > m) ? ref_level - m : 0;
        if (ref_level == 0) ref_phase = 0;
      end
    endcase
  endtask

  task automatic pulse_key(input bit on, input bit off);
    @(negedge m_clock);
    key_on  = on;
    key_off = off;
    @(negedge m_clock);
    key_on  = 1'b0;
    key_off = 1'b0;
    ref_pon  = ref_pon | on;
    ref_poff = ref_poff | off;
  endtask

  // Returns cycles from tick to step_done, or -1 if none within the budget
  task automatic pulse_tick(output int lat);
    @(negedge m_clock);
    tick = 1'b1;
    @(negedge m_clock);
    tick = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      if (step_done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge m_clock);
    end
  endtask

  task automatic test_reset();
    checks++; if (env_level !== 15'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", env_level); end
    checks++; if (env_phase !== 3'd0) begin errors++; $display("[TB] FAIL reset_phase: got %0d expected 0", env_phase); end
    checks++; if (step_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", step_done); end
    checks++; if (rt_bus.rt_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b expected 0", rt_bus.rt_read); end
    checks++; if (rt_bus.rt_adrs !== 7'd0) begin errors++; $display("[TB] FAIL reset_adrs: got %0d expected 0", rt_bus.rt_adrs); end
    checks++; if (tick_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", tick_overrun); end
  endtask

  task automatic test_attack_decay_sustain();
    bit d;
    int lat;
    ar = 7'd0; dr = 4'd0; sl = 4'd7; sr = 7'h40; sr_dec = 1'b1; rr = 5'd0; rr_exp = 1'b0;
    pulse_key(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      model_tick(d);
      pulse_tick(lat);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL ads_latency[%0d]: got %0d expected 3", i, lat); end
      checks++; if (env_level !== 15'(ref_level)) begin errors++; $display("[TB] FAIL ads_level[%0d]: got %0d expected %0d", i, env_level, ref_level); end
      checks++; if (env_phase !== 3'(ref_phase)) begin errors++; $display("[TB] FAIL ads_phase[%0d]: got %0d expected %0d", i, env_phase, ref_phase); end
    end
    checks++; if (env_level !== 15'd16384 || env_phase !== 3'd3) begin errors++; $display("[TB] FAIL sustain_hold: got %0d/%0d expected 16384/3", env_level, env_phase); end
    @(negedge m_clock);
    checks++; if (step_done !== 1'b0) begin errors++; $display("[TB] FAIL done_width: got %b expected 0", step_done); end
    ar = 7'h10;
    pulse_key(1'b1, 1'b1);
    model_tick(d);
    pulse_tick(lat);
    checks++; if (env_level !== 15'd1024 || env_phase !== 3'd1) begin errors++; $display("[TB] FAIL both_keys: got %0d/%0d expected 1024/1", env_level, env_phase); end
  endtask

  task automatic test_release_linear();
    bit d;
    int lat;
    ar = 7'h38; rr = 5'd14; rr_exp = 1'b0;
    pulse_key(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) pulse_key(1'b0, 1'b1);
      model_tick(d);
      pulse_tick(lat);
      checks++; if (lat !== (d ? 3 : -1)) begin errors++; $display("[TB] FAIL rel_latency[%0d]: got %0d expected %0d", i, lat, d ? 3 : -1); end
      checks++; if (env_level !== 15'(ref_level)) begin errors++; $display("[TB] FAIL rel_level[%0d]: got %0d expected %0d", i, env_level, ref_level); end
      checks++; if (env_phase !== 3'(ref_phase)) begin errors++; $display("[TB] FAIL rel_phase[%0d]: got %0d expected %0d", i, env_phase, ref_phase); end
    end
  endtask

  task automatic test_overrun();
    bit d;
    int lat;
    ar = 7'h20;
    pulse_key(1'b1, 1'b0);
    model_tick(d);
    @(negedge m_clock); tick = 1'b1;
    @(negedge m_clock);
    @(negedge m_clock); tick = 1'b0;
    @(negedge m_clock);
    checks++; if (step_done !== 1'b1 || env_level !== 15'(ref_level)) begin errors++; $display("[TB] FAIL ovr_step: got %b/%0d expected 1/%0d", step_done, env_level, ref_level); end
    checks++; if (tick_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", tick_overrun); end
    model_tick(d);
    pulse_tick(lat);
    checks++; if (tick_overrun !== 1'b1 || env_level !== 15'(ref_level)) begin errors++; $display("[TB] FAIL ovr_sticky: got %b/%0d expected 1/%0d", tick_overrun, env_level, ref_level); end
    pulse_key(1'b1, 1'b0);
    checks++; if (tick_overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", tick_overrun); end
  endtask

  task automatic test_reset_mid_apply();
    bit seen;
    ar = 7'd5;
    pulse_key(1'b1, 1'b0);
    @(negedge m_clock); tick = 1'b1;
    @(negedge m_clock); tick = 1'b0;
    @(negedge m_clock);
    p_reset = 1'b0;
    #1;
    checks++; if (env_phase !== 3'd0 || env_level !== 15'd0) begin errors++; $display("[TB] FAIL mid_reset_state: got %0d/%0d expected 0/0", env_phase, env_level); end
    checks++; if (rt_bus.rt_adrs !== 7'd0 || rt_bus.rt_read !== 1'b0 || step_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got %0d/%b/%b expected 0/0/0", rt_bus.rt_adrs, rt_bus.rt_read, step_done); end
    @(negedge m_clock);
    p_reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge m_clock);
      if (step_done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_no_done: got %b expected 0", seen); end
    ref_level = 0; ref_phase = 0; ref_pon = 0; ref_poff = 0;
  endtask

  task automatic test_random();
    bit d;
    int lat, r;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) pulse_key(1'b1, 1'b0);
      else if (r < 20) pulse_key(1'b0, 1'b1);
      else if (r < 24) pulse_key(1'b1, 1'b1);
      else begin
        ar     = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 40));
        dr     = 4'($urandom_range(0, 15));
        sl     = 4'($urandom_range(0, 15));
        sr     = 7'($urandom_range(0, 127));
        sr_dec = 1'($urandom_range(0, 1));
        rr     = 5'($urandom_range(0, 31));
        rr_exp = 1'($urandom_range(0, 1));
        model_tick(d);
        pulse_tick(lat);
        checks++; if (lat !== (d ? 3 : -1)) begin errors++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, d ? 3 : -1); end
        checks++; if (env_level !== 15'(ref_level)) begin errors++; $display("[TB] FAIL rnd_level[%0d]: got %0d expected %0d", i, env_level, ref_level); end
        checks++; if (env_phase !== 3'(ref_phase)) begin errors++; $display("[TB] FAIL rnd_phase[%0d]: got %0d expected %0d", i, env_phase, ref_phase); end
      end
    end
  endtask

  initial begin
    p_reset = 1'b0;
    tick = 1'b0; key_on = 1'b0; key_off = 1'b0;
    ar = '0; dr = '0; sl = '0; sr = '0; sr_dec = 1'b0; rr = '0; rr_exp = 1'b0;
    ref_level = 0; ref_phase = 0; ref_pon = 0; ref_poff = 0;
    repeat (3) @(negedge m_clock);
    p_reset = 1'b1;
    @(negedge m_clock);
    test_reset();
    test_attack_decay_sustain();
    test_release_linear();
    test_overrun();
    test_reset_mid_apply();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
